// File: rtl/ddr_rd_pkg.sv
// Shared types and constants for the DDR read engine: FSM state encoding,
// word size and the address boundary used by the optional 4 KiB burst split.
package ddr_rd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    DRAIN
  } rd_state_t;

  localparam int unsigned WORD_BYTES     = 64;
  localparam int unsigned WORD_SHIFT     = 6;
  localparam int unsigned BOUNDARY_BYTES = 4096;

endpackage

// File: rtl/ddr_rd_fifo.sv
// Word FIFO for the DDR read engine: synchronous, one-cycle read latency.
// head presents the most recently popped word and holds it until the next pop.
module ddr_rd_fifo
  import ddr_rd_pkg::*;
#(
  parameter int unsigned WIDTH = 512,
  parameter int unsigned DEPTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [WIDTH-1:0]             head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  // A push at full is only accepted when a pop frees the slot in the same cycle.
  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count != CW'(DEPTH)) || pop_ok);
  assign empty   = (count == '0);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop_ok) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        head   <= mem[rd_ptr];
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ddr_read_engine.sv
// DDR read engine: splits a byte-length read into credit-limited bursts and
// buffers returned words. Define DDR_RD_4K_SPLIT_EN to stop bursts at 4 KiB.
module ddr_read_engine
  import ddr_rd_pkg::*;
#(
  parameter int unsigned DDR_ADDR_LEN = 32,
  parameter int unsigned SINGLE_LEN   = 24,
  parameter int unsigned DATA_LEN     = 32,
  parameter int unsigned FIFO_DEPTH   = 64,
  parameter int unsigned BURST_MAX    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ddr_conf,
  input  logic [DDR_ADDR_LEN-1:0]   ddr_st_addr_in,
  input  logic [SINGLE_LEN-1:0]     ddr_len,
  output logic                      rd_req,
  output logic [DDR_ADDR_LEN-1:0]   rd_addr,
  output logic [4:0]                rd_beats,
  input  logic                      rd_ack,
  input  logic                      rd_valid,
  input  logic [DATA_LEN*16-1:0]    rd_data,
  output logic                      ddr_fifo_empty,
  input  logic                      ddr_fifo_req,
  output logic [DATA_LEN*16-1:0]    ddr_fifo_data,
  output logic                      idle
);

  localparam int unsigned WORD_W = DATA_LEN * 16;
  localparam int unsigned WCNT_W = SINGLE_LEN - WORD_SHIFT + 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W  = CNT_W + 2;

  rd_state_t               state, nxt;
  logic [DDR_ADDR_LEN-1:0] cur_addr;
  logic [WCNT_W-1:0]       remaining;
  logic [CNT_W-1:0]        in_flight;
  logic [CNT_W-1:0]        fifo_count;
  logic [SINGLE_LEN:0]     len_ext;
  logic [WCNT_W-1:0]       words_in;
  logic [WCNT_W-1:0]       burst_w;
  logic [4:0]              burst;
  logic                    credit_ok;
  logic                    ack_fire;
  logic                    push;

  assign len_ext  = {1'b0, ddr_len} + (SINGLE_LEN + 1)'(WORD_BYTES - 1);
  assign words_in = len_ext[SINGLE_LEN:WORD_SHIFT];

`ifdef DDR_RD_4K_SPLIT_EN
  localparam int unsigned BND_WORDS = BOUNDARY_BYTES / WORD_BYTES;
  localparam int unsigned BND_W     = $clog2(BND_WORDS + 1);
  logic [BND_W-1:0] bnd_words;
  assign bnd_words = BND_W'(BND_WORDS) - BND_W'(cur_addr[11:WORD_SHIFT]);
`endif

  always_comb begin
    burst_w = WCNT_W'(BURST_MAX);
    if (remaining < burst_w) burst_w = remaining;
`ifdef DDR_RD_4K_SPLIT_EN
    if (WCNT_W'(bnd_words) < burst_w) burst_w = WCNT_W'(bnd_words);
`endif
  end

  assign burst     = 5'(burst_w);
  assign credit_ok = (SUM_W'(fifo_count) + SUM_W'(in_flight) + SUM_W'(burst))
                     <= SUM_W'(FIFO_DEPTH);
  assign ack_fire  = (state == WAIT_ACK) && rd_ack;
  // Beats only enter the FIFO when owed; this also drops late beats after reset.
  assign push      = rd_valid && (in_flight != '0);

  always_comb begin
    nxt    = state;
    rd_req = 1'b0;
    idle   = 1'b0;
    unique case (state)
      IDLE: begin
        idle = (in_flight == '0);
        if (ddr_conf && (words_in != '0)) nxt = ISSUE;
      end
      ISSUE: if (credit_ok) nxt = WAIT_ACK;
      WAIT_ACK: begin
        rd_req = 1'b1;
        if (rd_ack) nxt = (remaining != WCNT_W'(rd_beats)) ? ISSUE : DRAIN;
      end
      DRAIN: if (in_flight == '0) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      in_flight <= '0;
      rd_addr   <= '0;
      rd_beats  <= '0;
    end else begin
      state     <= nxt;
      in_flight <= in_flight + (ack_fire ? CNT_W'(rd_beats) : '0) - CNT_W'(push);
      unique case (state)
        IDLE: if (ddr_conf) begin
          cur_addr  <= ddr_st_addr_in & ~DDR_ADDR_LEN'(WORD_BYTES - 1);
          remaining <= words_in;
        end
        ISSUE: if (credit_ok) begin
          rd_addr  <= cur_addr;
          rd_beats <= burst;
        end
        WAIT_ACK: if (rd_ack) begin
          cur_addr  <= cur_addr + (DDR_ADDR_LEN'(rd_beats) << WORD_SHIFT);
          remaining <= remaining - WCNT_W'(rd_beats);
        end
        default: ;
      endcase
    end
  end

  ddr_rd_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (rd_data),
    .pop       (ddr_fifo_req),
    .empty     (ddr_fifo_empty),
    .count     (fifo_count),
    .head      (ddr_fifo_data)
  );

endmodule
